// File: rtl/decode_stage.sv
// RV32I decode stage: 32x32 register file with write-through, immediate decode,
// load-use / redirect control to fetch. Optional early JAL redirect: DECODE_JAL_EARLY_EN.
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_pc,
    input  logic [31:0] fd_instr,
    input  logic        ex_stall,
    input  logic        ex_br_en,
    input  logic [31:0] ex_br_addr,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic        br_en,
    output logic [31:0] br_addr,
    output logic        de_valid,
    output logic [31:0] de_pc,
    output logic [31:0] de_instr,
    output logic [31:0] de_rs1_val,
    output logic [31:0] de_rs2_val,
    output logic [31:0] de_imm,
    output logic [4:0]  de_rd,
    output logic        de_we,
    output logic        de_is_load
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic [31:0] regs [0:31];

    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        known;
    logic        use_rs1;
    logic        use_rs2;
    logic        writes_rd;
    logic        is_load;
    logic [31:0] imm;
    logic [31:0] rf_rs1;
    logic [31:0] rf_rs2;
    logic        lu;
    logic        jal_early;
    logic        load_bubble;

    assign opcode = fd_instr[6:0];
    assign rs1    = fd_instr[19:15];
    assign rs2    = fd_instr[24:20];
    assign rd     = fd_instr[11:7];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Write-through: a writeback in this cycle is visible to this cycle's decode.
    always_comb begin
        rf_rs1 = '0;
        rf_rs2 = '0;
        if (rs1 != 5'd0) rf_rs1 = (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
        if (rs2 != 5'd0) rf_rs2 = (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];
    end

    always_comb begin
        known     = 1'b1;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        imm       = '0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                writes_rd = 1'b1;
                imm       = {fd_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                writes_rd = 1'b1;
                imm       = {{11{fd_instr[31]}}, fd_instr[31], fd_instr[19:12],
                             fd_instr[20], fd_instr[30:21], 1'b0};
            end
            OP_JALR, OP_IMM: begin
                writes_rd = 1'b1;
                use_rs1   = 1'b1;
                imm       = {{20{fd_instr[31]}}, fd_instr[31:20]};
            end
            OP_LOAD: begin
                writes_rd = 1'b1;
                use_rs1   = 1'b1;
                is_load   = 1'b1;
                imm       = {{20{fd_instr[31]}}, fd_instr[31:20]};
            end
            OP_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{20{fd_instr[31]}}, fd_instr[31:25], fd_instr[11:7]};
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{19{fd_instr[31]}}, fd_instr[31], fd_instr[7],
                           fd_instr[30:25], fd_instr[11:8], 1'b0};
            end
            OP_OP: begin
                writes_rd = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            default: known = 1'b0;
        endcase
    end

    assign lu = de_valid && de_is_load && (de_rd != 5'd0) &&
                ((use_rs1 && rs1 == de_rd) || (use_rs2 && rs2 == de_rd));

`ifdef DECODE_JAL_EARLY_EN
    assign jal_early = (opcode == OP_JAL);
`else
    assign jal_early = 1'b0;
`endif

    // br_en forces stall low because fetch ignores a redirect while stalled.
    always_comb begin
        stall   = 1'b0;
        br_en   = 1'b0;
        br_addr = '0;
        if (ex_br_en) begin
            br_en   = 1'b1;
            br_addr = ex_br_addr;
        end else if (ex_stall || lu) begin
            stall = 1'b1;
        end else if (jal_early) begin
            br_en   = 1'b1;
            br_addr = fd_pc + imm;
        end
    end

    assign load_bubble = reset || ex_br_en || (!ex_stall && (lu || !known));

    always_ff @(posedge clock) begin
        if (load_bubble) begin
            de_valid   <= 1'b0;
            de_pc      <= RESET_PC;
            de_instr   <= '0;
            de_rs1_val <= '0;
            de_rs2_val <= '0;
            de_imm     <= '0;
            de_rd      <= '0;
            de_we      <= 1'b0;
            de_is_load <= 1'b0;
        end else if (!ex_stall) begin
            de_valid   <= 1'b1;
            de_pc      <= fd_pc;
            de_instr   <= fd_instr;
            de_rs1_val <= use_rs1 ? rf_rs1 : 32'h0;
            de_rs2_val <= use_rs2 ? rf_rs2 : 32'h0;
            de_imm     <= imm;
            de_rd      <= writes_rd ? rd : 5'd0;
            de_we      <= writes_rd && (rd != 5'd0);
            de_is_load <= is_load;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected de_* pushed when driven, popped after the edge.
module tb_decode_stage;

    localparam logic [31:0] RP = 32'h8000_0000;
`ifdef DECODE_JAL_EARLY_EN
    localparam bit JAL_EARLY = 1'b1;
`else
    localparam bit JAL_EARLY = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fd_pc, fd_instr, ex_br_addr, wb_data;
    logic        ex_stall, ex_br_en, wb_en;
    logic [4:0]  wb_rd;
    logic        stall, br_en, de_valid, de_we, de_is_load;
    logic [31:0] br_addr, de_pc, de_instr, de_rs1_val, de_rs2_val, de_imm;
    logic [4:0]  de_rd;

    decode_stage #(.RESET_PC(RP)) dut (
        .clock(clock), .reset(reset), .fd_pc(fd_pc), .fd_instr(fd_instr),
        .ex_stall(ex_stall), .ex_br_en(ex_br_en), .ex_br_addr(ex_br_addr),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .br_en(br_en), .br_addr(br_addr),
        .de_valid(de_valid), .de_pc(de_pc), .de_instr(de_instr),
        .de_rs1_val(de_rs1_val), .de_rs2_val(de_rs2_val), .de_imm(de_imm),
        .de_rd(de_rd), .de_we(de_we), .de_is_load(de_is_load)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, instr, rs1, rs2, imm;
        logic [4:0]  rd;
        logic        we, ld;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic exp_t mk(input logic v, input logic [31:0] pc, instr, r1, r2, imm,
                                input logic [4:0] rd, input logic we, ld);
        exp_t e;
        e.valid = v; e.pc = pc; e.instr = instr; e.rs1 = r1; e.rs2 = r2;
        e.imm = imm; e.rd = rd; e.we = we; e.ld = ld;
        return e;
    endfunction

    function automatic exp_t bub();
        return mk(1'b0, RP, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    endfunction

    task automatic drv(input logic [31:0] pc, instr, input logic xs, xb,
                       input logic [31:0] xba, input logic we, input logic [4:0] rd,
                       input logic [31:0] d);
        fd_pc = pc; fd_instr = instr; ex_stall = xs; ex_br_en = xb;
        ex_br_addr = xba; wb_en = we; wb_rd = rd; wb_data = d;
    endtask

    // Called at posedge+1 after drv: checks combinational controls, then de_* after the edge.
    task automatic run_cycle(input exp_t e, input logic s, input logic b, input logic [31:0] ba);
        exp_t g;
        #4;
        chk("stall", {31'b0, stall}, {31'b0, s});
        chk("br_en", {31'b0, br_en}, {31'b0, b});
        chk("br_addr", br_addr, ba);
        sb.push_back(e);
        @(posedge clock); #1;
        g = sb.pop_front();
        chk("de_valid", {31'b0, de_valid}, {31'b0, g.valid});
        chk("de_pc", de_pc, g.pc);
        chk("de_instr", de_instr, g.instr);
        chk("de_rs1_val", de_rs1_val, g.rs1);
        chk("de_rs2_val", de_rs2_val, g.rs2);
        chk("de_imm", de_imm, g.imm);
        chk("de_rd", {27'b0, de_rd}, {27'b0, g.rd});
        chk("de_we", {31'b0, de_we}, {31'b0, g.we});
        chk("de_is_load", {31'b0, de_is_load}, {31'b0, g.ld});
    endtask

    localparam logic [31:0] I_ADD430 = 32'h0001_8233; // add  x4,x3,x0
    localparam logic [31:0] I_ADDI   = 32'hFFF2_8313; // addi x6,x5,-1
    localparam logic [31:0] I_SW     = 32'h0053_2423; // sw   x5,8(x6)
    localparam logic [31:0] I_LW     = 32'h0000_A383; // lw   x7,0(x1)
    localparam logic [31:0] I_ADD872 = 32'h0023_8433; // add  x8,x7,x2
    localparam logic [31:0] I_LUI    = 32'h1234_54B7; // lui  x9,0x12345
    localparam logic [31:0] I_BEQ    = 32'hFE52_8EE3; // beq  x5,x5,-4
    localparam logic [31:0] I_JAL    = 32'h0100_00EF; // jal  x1,+16
    localparam logic [31:0] I_ADD400 = 32'h0000_0233; // add  x4,x0,x0
    localparam logic [31:0] I_AUIPC  = 32'h0000_1597; // auipc x11,0x1
    localparam logic [31:0] I_JALR   = 32'h0000_8067; // jalr x0,0(x1)

    initial begin
        exp_t held;
        reset = 1'b1;
        drv(32'h0, 32'h0, 0, 0, 32'h0, 1, 5'd3, 32'h55);
        @(posedge clock); #1;
        // Reset cycle; the x3 write must be dropped.
        run_cycle(bub(), 0, 0, 32'h0);
        reset = 1'b0;

        drv(32'h0C, 32'h0, 0, 0, 32'h0, 1, 5'd5, 32'hDEAD_BEEF);
        run_cycle(bub(), 0, 0, 32'h0);
        drv(32'h10, I_ADD430, 0, 0, 32'h0, 1, 5'd1, 32'h100);
        run_cycle(mk(1, 32'h10, I_ADD430, 0, 0, 0, 5'd4, 1, 0), 0, 0, 32'h0);
        drv(32'h14, I_ADDI, 0, 0, 32'h0, 1, 5'd2, 32'h22);
        run_cycle(mk(1, 32'h14, I_ADDI, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF, 5'd6, 1, 0), 0, 0, 32'h0);
        drv(32'h18, I_SW, 0, 0, 32'h0, 1, 5'd6, 32'h600);
        run_cycle(mk(1, 32'h18, I_SW, 32'h600, 32'hDEAD_BEEF, 32'h8, 5'd0, 0, 0), 0, 0, 32'h0);

        // Load-use: one bubble, then the dependent add issues.
        drv(32'h1C, I_LW, 0, 0, 32'h0, 0, 5'd0, 32'h0);
        run_cycle(mk(1, 32'h1C, I_LW, 32'h100, 0, 0, 5'd7, 1, 1), 0, 0, 32'h0);
        drv(32'h20, I_ADD872, 0, 0, 32'h0, 0, 5'd0, 32'h0);
        run_cycle(bub(), 1, 0, 32'h0);
        drv(32'h20, I_ADD872, 0, 0, 32'h0, 1, 5'd7, 32'h777);
        run_cycle(mk(1, 32'h20, I_ADD872, 32'h777, 32'h22, 0, 5'd8, 1, 0), 0, 0, 32'h0);

        drv(32'h24, I_LUI, 0, 0, 32'h0, 0, 5'd0, 32'h0);
        run_cycle(mk(1, 32'h24, I_LUI, 0, 0, 32'h1234_5000, 5'd9, 1, 0), 0, 0, 32'h0);
        drv(32'h28, I_BEQ, 0, 0, 32'h0, 0, 5'd0, 32'h0);
        run_cycle(mk(1, 32'h28, I_BEQ, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 5'd0, 0, 0),
                  0, 0, 32'h0);
        drv(32'h100, I_JAL, 0, 0, 32'h0, 0, 5'd0, 32'h0);
        run_cycle(mk(1, 32'h100, I_JAL, 0, 0, 32'h10, 5'd1, 1, 0),
                  0, JAL_EARLY, JAL_EARLY ? 32'h110 : 32'h0);
        drv(32'h104, 32'h0, 0, 0, 32'h0, 0, 5'd0, 32'h0);
        run_cycle(bub(), 0, 0, 32'h0);

        // Execute redirect wins over an active load-use hazard.
        drv(32'h30, I_LW, 0, 0, 32'h0, 0, 5'd0, 32'h0);
        run_cycle(mk(1, 32'h30, I_LW, 32'h100, 0, 0, 5'd7, 1, 1), 0, 0, 32'h0);
        drv(32'h34, I_ADD872, 0, 1, 32'h40, 0, 5'd0, 32'h0);
        run_cycle(bub(), 0, 1, 32'h40);

        drv(32'h40, I_ADDI, 0, 0, 32'h0, 0, 5'd0, 32'h0);
        held = mk(1, 32'h40, I_ADDI, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF, 5'd6, 1, 0);
        run_cycle(held, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drv(32'h44, I_LUI, 1, 0, 32'h0, 1, 5'd0, 32'hFFFF_FFFF);
            run_cycle(held, 1, 0, 32'h0);
        end
        // x0 stays zero, including through the write-through path.
        drv(32'h44, I_ADD400, 0, 0, 32'h0, 1, 5'd0, 32'h1234_5678);
        run_cycle(mk(1, 32'h44, I_ADD400, 0, 0, 0, 5'd4, 1, 0), 0, 0, 32'h0);

        drv(32'h48, 32'h0000_007F, 0, 0, 32'h0, 0, 5'd0, 32'h0);
        run_cycle(bub(), 0, 0, 32'h0);
        drv(32'h4C, I_AUIPC, 0, 0, 32'h0, 0, 5'd0, 32'h0);
        run_cycle(mk(1, 32'h4C, I_AUIPC, 0, 0, 32'h1000, 5'd11, 1, 0), 0, 0, 32'h0);
        drv(32'h50, I_JALR, 0, 0, 32'h0, 0, 5'd0, 32'h0);
        run_cycle(mk(1, 32'h50, I_JALR, 32'h100, 0, 0, 5'd0, 0, 0), 0, 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
